scheduler_sorted_n: RTL and testbench

//  Parametrised successor of the partial scheduler: holds NSLOT running tasks internally as a priority-sorted slot array.

---
 rtl/scheduler_sorted_n.sv | 168 ++++++++++++++++
 tb/tb_scheduler_sorted_n.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/scheduler_sorted_n.sv
// Priority-sorted task scheduler: NSLOT slots kept sorted by prio (FIFO among equals),
// with insert/evict, remove-by-id and head remaining-time countdown with completion report.
module scheduler_sorted_n #(
  parameter int W     = 59,
  parameter int NSLOT = 8,
  parameter int PW    = 8,
  parameter int TW    = 16,
  localparam int IDW  = W - 1 - PW - TW,
  localparam int OW   = $clog2(NSLOT + 1),
  localparam int IW   = $clog2(NSLOT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic                 action,
  input  logic                 subtract_en,
  input  logic [W-2:0]         task_in,
  output logic                 busy_ready,
  output logic                 v_exch,
  output logic                 v_active,
  output logic [W-2:0]         task_exch,
  output logic                 v_done,
  output logic [IDW-1:0]       done_id,
  output logic [OW-1:0]        occupancy,
  output logic [NSLOT*W-1:0]   running_tasks_out,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_COMMIT = 2'd2} state_t;

  // Handshake: a command is taken on any rising edge where wr=1 and busy_ready=0;
  // busy_ready stays high until the cycle in which the command's result pulses appear.
  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           hit_q, hit_d, act_q, act_d;
  logic [W-2:0]   pend_q, pend_d, exch_q, exch_d;
  logic [W-1:0]   slot_q [NSLOT];
  logic [W-1:0]   slot_d [NSLOT];
  logic [OW-1:0]  occ_q, occ_d;
  logic [IDW-1:0] done_id_q, done_id_d;
  logic           v_exch_q, v_exch_d, v_active_q, v_active_d, v_done_q, v_done_d;
  logic [W-1:0]   cur;
  logic           scan_hit;

  always_comb begin
    cur = slot_q[idx_q];
    if (act_q) scan_hit = !cur[W-1] || (pend_q[W-2 -: PW] > cur[W-2 -: PW]);
    else       scan_hit = cur[W-1] && (cur[IDW-1:0] == pend_q[IDW-1:0]);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hit_d      = hit_q;
    act_d      = act_q;
    pend_d     = pend_q;
    slot_d     = slot_q;
    occ_d      = occ_q;
    exch_d     = exch_q;
    done_id_d  = done_id_q;
    v_exch_d   = 1'b0;
    v_active_d = 1'b0;
    v_done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr) begin
          act_d   = action;
          pend_d  = task_in;
          idx_d   = '0;
          hit_d   = 1'b0;
          state_d = S_SCAN;
        end else if (subtract_en && slot_q[0][W-1]) begin
          if (slot_q[0][IDW +: TW] >= TW'(2)) begin
            slot_d[0][IDW +: TW] = slot_q[0][IDW +: TW] - TW'(1);
          end else begin
            for (int i = 0; i < NSLOT - 1; i++) slot_d[i] = slot_q[i+1];
            slot_d[NSLOT-1] = '0;
            v_done_d  = 1'b1;
            done_id_d = slot_q[0][IDW-1:0];
            occ_d     = occ_q - OW'(1);
          end
        end
      end
      S_SCAN: begin
        if (scan_hit) begin
          hit_d   = 1'b1;
          state_d = S_COMMIT;
        end else if (idx_q == IW'(NSLOT - 1)) begin
          state_d = S_COMMIT;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        if (act_q) begin
          if (hit_q) begin
            for (int i = 1; i < NSLOT; i++)
              if (i > int'(idx_q)) slot_d[i] = slot_q[i-1];
            slot_d[idx_q] = {1'b1, pend_q};
            v_active_d = 1'b1;
            // A valid tail slot means the array was full and the tail falls off.
            if (slot_q[NSLOT-1][W-1]) begin
              v_exch_d = 1'b1;
              exch_d   = slot_q[NSLOT-1][W-2:0];
            end else begin
              occ_d = occ_q + OW'(1);
            end
          end else begin
            v_exch_d = 1'b1;
            exch_d   = pend_q;
          end
        end else if (hit_q) begin
          for (int i = 0; i < NSLOT - 1; i++)
            if (i >= int'(idx_q)) slot_d[i] = slot_q[i+1];
          slot_d[NSLOT-1] = '0;
          v_active_d = 1'b1;
          occ_d      = occ_q - OW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      hit_q      <= 1'b0;
      act_q      <= 1'b0;
      pend_q     <= '0;
      occ_q      <= '0;
      exch_q     <= '0;
      done_id_q  <= '0;
      v_exch_q   <= 1'b0;
      v_active_q <= 1'b0;
      v_done_q   <= 1'b0;
      for (int i = 0; i < NSLOT; i++) slot_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hit_q      <= hit_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      occ_q      <= occ_d;
      exch_q     <= exch_d;
      done_id_q  <= done_id_d;
      v_exch_q   <= v_exch_d;
      v_active_q <= v_active_d;
      v_done_q   <= v_done_d;
      for (int i = 0; i < NSLOT; i++) slot_q[i] <= slot_d[i];
    end
  end

  for (genvar g = 0; g < NSLOT; g++) begin : g_flat
    assign running_tasks_out[g*W +: W] = slot_q[g];
  end

  assign busy_ready = (state_q != S_IDLE);
  assign v_exch     = v_exch_q;
  assign v_active   = v_active_q;
  assign v_done     = v_done_q;
  assign task_exch  = exch_q;
  assign done_id    = done_id_q;
  assign occupancy  = occ_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_scheduler_sorted_n.sv
// Bench for scheduler_sorted_n (NSLOT=4): directed scenarios then a randomized run,
// checked against a queue-based sorted-list reference model.
module tb_scheduler_sorted_n;
  localparam int W   = 59;
  localparam int NS  = 4;
  localparam int IDW = 34;
  localparam int OW  = 3;

  logic              clk = 1'b0;
  logic              rst, wr, action, subtract_en;
  logic [W-2:0]      task_in;
  logic              busy_ready, v_exch, v_active, v_done;
  logic [W-2:0]      task_exch;
  logic [IDW-1:0]    done_id;
  logic [OW-1:0]     occupancy;
  logic [NS*W-1:0]   running_tasks_out;
  logic [1:0]        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-2:0]   model_q[$];
  logic [W-2:0]   last_exch;
  logic [IDW-1:0] last_done;

  scheduler_sorted_n #(.NSLOT(NS)) dut (
    .clk(clk), .rst(rst), .wr(wr), .action(action), .subtract_en(subtract_en),
    .task_in(task_in), .busy_ready(busy_ready), .v_exch(v_exch), .v_active(v_active),
    .task_exch(task_exch), .v_done(v_done), .done_id(done_id), .occupancy(occupancy),
    .running_tasks_out(running_tasks_out), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-2:0] mk(input int p, input int r, input int id);
    logic [7:0]  pp;
    logic [15:0] rr;
    logic [33:0] ii;
    pp = p[7:0];
    rr = r[15:0];
    ii = {2'b00, id};
    return {pp, rr, ii};
  endfunction

  function automatic logic [W-2:0] rnd_task();
    return mk($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 15));
  endfunction

  function automatic logic [NS*W-1:0] exp_arr();
    logic [NS*W-1:0] a;
    a = '0;
    for (int i = 0; i < model_q.size(); i++) a[i*W +: W] = {1'b1, model_q[i]};
    return a;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_occupancy"}, occupancy, model_q.size());
    check({tag, "_array"}, running_tasks_out, exp_arr());
    check({tag, "_task_exch"}, task_exch, last_exch);
    check({tag, "_done_id"}, done_id, last_done);
  endtask

  // Issue one command, model its effect, and check latency, pulses and resulting array.
  task automatic do_cmd(input logic act, input logic [W-2:0] t, input logic sub, input bit noise);
    int   k, lat, n;
    bit   e_act, e_x;
    logic spur;
    logic [W-2:0] tmp;
    k = -1; e_act = 0; e_x = 0;
    if (act) begin
      for (int i = 0; i < model_q.size(); i++)
        if (t[W-2 -: 8] > model_q[i][W-2 -: 8]) begin k = i; break; end
      if (k < 0 && model_q.size() < NS) k = model_q.size();
      if (k >= 0) begin
        model_q.insert(k, t);
        e_act = 1;
        if (model_q.size() > NS) begin e_x = 1; tmp = model_q.pop_back(); last_exch = tmp; end
      end else begin
        e_x = 1; last_exch = t;
      end
    end else begin
      for (int i = 0; i < model_q.size(); i++)
        if (t[IDW-1:0] == model_q[i][IDW-1:0]) begin k = i; break; end
      if (k >= 0) begin model_q.delete(k); e_act = 1; end
    end
    lat = (k >= 0) ? k + 3 : NS + 2;
    wr = 1'b1; action = act; task_in = t; subtract_en = sub;
    tick();
    wr = 1'b0; subtract_en = 1'b0;
    n = 1; spur = 1'b0;
    while (busy_ready === 1'b1 && n < 40) begin
      spur = spur | v_active | v_exch | v_done;
      if (noise) begin
        wr = 1'($urandom_range(0, 1)); action = 1'($urandom_range(0, 1)); task_in = rnd_task();
        subtract_en = 1'($urandom_range(0, 1));
      end
      tick();
      n++;
    end
    wr = 1'b0; subtract_en = 1'b0;
    check("latency", n, lat);
    check("early_pulse", spur, 1'b0);
    check("v_active", v_active, e_act);
    check("v_exch", v_exch, e_x);
    check("v_done", v_done, 1'b0);
    check_state("cmd");
  endtask

  task automatic do_sub();
    bit e_done;
    logic [W-2:0] tmp;
    e_done = 0;
    if (model_q.size() > 0) begin
      tmp = model_q[0];
      if (tmp[IDW +: 16] >= 16'd2) begin
        tmp[IDW +: 16] = tmp[IDW +: 16] - 16'd1;
        model_q[0] = tmp;
      end else begin
        last_done = tmp[IDW-1:0];
        tmp = model_q.pop_front();
        e_done = 1;
      end
    end
    subtract_en = 1'b1;
    tick();
    subtract_en = 1'b0;
    check("sub_v_done", v_done, e_done);
    check("sub_busy", busy_ready, 1'b0);
    check("sub_v_active", v_active, 1'b0);
    check_state("sub");
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_busy"}, busy_ready, 1'b0);
    check({tag, "_pulses"}, {v_exch, v_active, v_done}, 3'b000);
    check({tag, "_occupancy"}, occupancy, 0);
    check({tag, "_array"}, running_tasks_out, 0);
    check({tag, "_task_exch"}, task_exch, 0);
    check({tag, "_done_id"}, done_id, 0);
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; action = 1'b0; subtract_en = 1'b0; task_in = '0;
    last_exch = '0; last_done = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    reset_check("reset");

    // Sorted insert with FIFO among equal priorities.
    do_cmd(1'b1, mk(5, 10, 1), 1'b0, 0);
    do_cmd(1'b1, mk(9, 3, 2), 1'b0, 0);
    do_cmd(1'b1, mk(5, 10, 7), 1'b0, 0);
    do_cmd(1'b1, mk(1, 10, 4), 1'b0, 0);
    check("full_occupancy", occupancy, 4);

    // Full array: eviction of the tail, then outright rejection.
    do_cmd(1'b1, mk(6, 10, 8), 1'b0, 0);
    check("evicted_prio1", task_exch, mk(1, 10, 4));
    do_cmd(1'b1, mk(0, 10, 9), 1'b0, 0);
    check("rejected_task", task_exch, mk(0, 10, 9));

    // Remove: slot 1 hit, then unknown id.
    do_cmd(1'b0, mk(0, 0, 8), 1'b0, 0);
    do_cmd(1'b0, mk(0, 0, 99), 1'b0, 0);

    // Head countdown from rem=3 to completion.
    do_sub(); do_sub(); do_sub();
    check("completed_id", done_id, 2);

    // wr and subtract_en in the same idle cycle: the command wins.
    do_cmd(1'b1, mk(3, 2, 11), 1'b1, 0);

    // Reset in the middle of a scan.
    wr = 1'b1; action = 1'b1; task_in = mk(0, 5, 12);
    tick();
    wr = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_q.delete(); last_exch = '0; last_done = '0;
    reset_check("mid_scan_reset");
    do_cmd(1'b1, mk(4, 1, 13), 1'b0, 0);

    // Randomized run with collisions and ignored wr during busy.
    for (int i = 0; i < 2000; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 5)      do_cmd(1'b1, rnd_task(), 1'($urandom_range(0, 1)), 1);
      else if (sel < 8) do_cmd(1'b0, rnd_task(), 1'($urandom_range(0, 1)), 1);
      else              do_sub();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
